// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file with rename tags.
// A tag of zero means the committed value is current; 1..32 name a ROB slot+1.
package register_file_pkg;
  localparam int REG_NUM  = 32;
  localparam int DATA_W   = 32;
  localparam int ROB_ID_W = 6;
  localparam int REG_W    = 5;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [REG_W-1:0]    reg_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  localparam data_t   DATA_RESET   = {DATA_W{1'b0}};
  localparam reg_t    REG_RESET    = {REG_W{1'b0}};
  localparam rob_id_t ROB_ID_RESET = {ROB_ID_W{1'b0}};
  localparam logic    TRUE         = 1'b1;
  localparam logic    FALSE        = 1'b0;

  // A read of rs sees the retiring value only when it retires the producer the tag is waiting on.
  function automatic logic bypass_hit(input logic commit, input reg_t rd_rob, input reg_t rs,
                                      input rob_id_t tag, input rob_id_t q_rob);
    return commit && (rd_rob == rs) && (rs != REG_RESET) && (tag == q_rob);
  endfunction
endpackage

// File: rtl/register_file_if.sv
// Dispatcher read/rename and ROB commit/rollback bus of the register file.
interface register_file_if;
  import register_file_pkg::*;

  reg_t    rs1_from_dispatcher;
  reg_t    rs2_from_dispatcher;
  data_t   V1_to_dispatcher;
  rob_id_t Q1_to_dispatcher;
  data_t   V2_to_dispatcher;
  rob_id_t Q2_to_dispatcher;
  logic    enable_from_dispatcher;
  reg_t    rd_from_dispatcher;
  rob_id_t rob_id_from_dispatcher;
  logic    commit_flag;
  reg_t    rd_from_rob;
  data_t   V_from_rob;
  rob_id_t Q_from_rob;
  logic    rollback_flag;

  modport master (
    output rs1_from_dispatcher, rs2_from_dispatcher,
    input  V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher,
    output enable_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
    output commit_flag, rd_from_rob, V_from_rob, Q_from_rob, rollback_flag
  );

  modport slave (
    input  rs1_from_dispatcher, rs2_from_dispatcher,
    output V1_to_dispatcher, Q1_to_dispatcher, V2_to_dispatcher, Q2_to_dispatcher,
    input  enable_from_dispatcher, rd_from_dispatcher, rob_id_from_dispatcher,
    input  commit_flag, rd_from_rob, V_from_rob, Q_from_rob, rollback_flag
  );
endinterface

// File: rtl/register_file_chk.sv
// Protocol checker for the register file bus: a live rename must carry a nonzero ROB id.
module register_file_chk
  import register_file_pkg::*;
(
  input logic    clk_in,
  input logic    rst_in,
  input logic    rdy_in,
  input logic    enable_s,
  input reg_t    rd_s,
  input rob_id_t rob_id_s,
  input logic    rollback_s
);
  a_rename_id_nonzero: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && enable_s && (rd_s != REG_RESET) && !rollback_s) |-> (rob_id_s != ROB_ID_RESET));
endmodule

// File: rtl/register_file.sv
// 32 x 32-bit architectural register file with per-register youngest-producer tags,
// combinational operand reads with commit bypass, rename, commit and rollback flush.
module register_file
  import register_file_pkg::*;
(
  input logic           clk_in,
  input logic           rst_in,
  input logic           rdy_in,
  register_file_if.slave rf_bus
);
  data_t   data_r [REG_NUM];
  rob_id_t tag_r  [REG_NUM];

  logic    commit_live_s;
  logic    rename_live_s;
  logic    rename_same_rd_s;
  data_t   v1_s;
  data_t   v2_s;
  rob_id_t q1_s;
  rob_id_t q2_s;

  assign commit_live_s    = rf_bus.commit_flag && (rf_bus.rd_from_rob != REG_RESET);
  assign rename_live_s    = rf_bus.enable_from_dispatcher && (rf_bus.rd_from_dispatcher != REG_RESET)
                            && !rf_bus.rollback_flag;
  assign rename_same_rd_s = rename_live_s && (rf_bus.rd_from_dispatcher == rf_bus.rd_from_rob);

  // State update: commit data write, tag clear unless renamed again, rename, rollback flush.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        data_r[i] <= DATA_RESET;
        tag_r[i]  <= ROB_ID_RESET;
      end
    end else if (rdy_in) begin
      if (commit_live_s) begin
        data_r[rf_bus.rd_from_rob] <= rf_bus.V_from_rob;
      end
      if (rf_bus.rollback_flag) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_r[i] <= ROB_ID_RESET;
        end
      end else begin
        if (commit_live_s && !rename_same_rd_s && (tag_r[rf_bus.rd_from_rob] == rf_bus.Q_from_rob)) begin
          tag_r[rf_bus.rd_from_rob] <= ROB_ID_RESET;
        end
        if (rename_live_s) begin
          tag_r[rf_bus.rd_from_dispatcher] <= rf_bus.rob_id_from_dispatcher;
        end
      end
    end
  end

  // Operand read port 1: x0 reads zero, matching commit bypasses, else current state.
  always_comb begin
    v1_s = data_r[rf_bus.rs1_from_dispatcher];
    q1_s = tag_r[rf_bus.rs1_from_dispatcher];
    if (rf_bus.rs1_from_dispatcher == REG_RESET) begin
      v1_s = DATA_RESET;
      q1_s = ROB_ID_RESET;
    end else if (bypass_hit(rf_bus.commit_flag, rf_bus.rd_from_rob, rf_bus.rs1_from_dispatcher,
                            tag_r[rf_bus.rs1_from_dispatcher], rf_bus.Q_from_rob)) begin
      v1_s = rf_bus.V_from_rob;
      q1_s = ROB_ID_RESET;
    end else begin
      v1_s = data_r[rf_bus.rs1_from_dispatcher];
      q1_s = tag_r[rf_bus.rs1_from_dispatcher];
    end
  end

  // Operand read port 2, same rules as port 1.
  always_comb begin
    v2_s = data_r[rf_bus.rs2_from_dispatcher];
    q2_s = tag_r[rf_bus.rs2_from_dispatcher];
    if (rf_bus.rs2_from_dispatcher == REG_RESET) begin
      v2_s = DATA_RESET;
      q2_s = ROB_ID_RESET;
    end else if (bypass_hit(rf_bus.commit_flag, rf_bus.rd_from_rob, rf_bus.rs2_from_dispatcher,
                            tag_r[rf_bus.rs2_from_dispatcher], rf_bus.Q_from_rob)) begin
      v2_s = rf_bus.V_from_rob;
      q2_s = ROB_ID_RESET;
    end else begin
      v2_s = data_r[rf_bus.rs2_from_dispatcher];
      q2_s = tag_r[rf_bus.rs2_from_dispatcher];
    end
  end

  assign rf_bus.V1_to_dispatcher = v1_s;
  assign rf_bus.Q1_to_dispatcher = q1_s;
  assign rf_bus.V2_to_dispatcher = v2_s;
  assign rf_bus.Q2_to_dispatcher = q2_s;
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a state model checked every negedge plus literal pins.
module tb_register_file;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b1;

  register_file_if bus ();

  register_file dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rf_bus (bus)
  );

  register_file_chk u_chk (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .enable_s   (bus.enable_from_dispatcher),
    .rd_s       (bus.rd_from_dispatcher),
    .rob_id_s   (bus.rob_id_from_dispatcher),
    .rollback_s (bus.rollback_flag)
  );

  always #5 clk_in = ~clk_in;

  int checks_n = 0;
  int errors_n = 0;
  logic        model_ok = 1'b0;
  logic [31:0] m_data [32];
  logic [5:0]  m_tag  [32];

  // Architectural meaning of each request, applied at the clock edge.
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] <= 32'd0;
        m_tag[i]  <= 6'd0;
      end
      model_ok <= 1'b1;
    end else if (rdy_in) begin
      if (bus.commit_flag && bus.rd_from_rob != 5'd0)
        m_data[bus.rd_from_rob] <= bus.V_from_rob;
      if (bus.rollback_flag) begin
        for (int i = 0; i < 32; i++) m_tag[i] <= 6'd0;
      end else begin
        if (bus.commit_flag && bus.rd_from_rob != 5'd0 && m_tag[bus.rd_from_rob] == bus.Q_from_rob)
          m_tag[bus.rd_from_rob] <= 6'd0;
        if (bus.enable_from_dispatcher && bus.rd_from_dispatcher != 5'd0)
          m_tag[bus.rd_from_dispatcher] <= bus.rob_id_from_dispatcher;
      end
    end
  end

  function automatic logic [37:0] expect_read(input logic [4:0] idx);
    if (idx == 5'd0) return 38'd0;
    if (bus.commit_flag && bus.rd_from_rob == idx && m_tag[idx] == bus.Q_from_rob)
      return {bus.V_from_rob, 6'd0};
    return {m_data[idx], m_tag[idx]};
  endfunction

  // Compare both read ports against the model every cycle once reset has taken effect.
  always @(negedge clk_in) begin
    logic [37:0] e1;
    logic [37:0] e2;
    if (model_ok && !rst_in) begin
      e1 = expect_read(bus.rs1_from_dispatcher);
      e2 = expect_read(bus.rs2_from_dispatcher);
      checks_n = checks_n + 1;
      if ({bus.V1_to_dispatcher, bus.Q1_to_dispatcher} !== e1) begin
        errors_n = errors_n + 1;
        $display("FAIL model_rs1 t=%0t got V=%h Q=%0d want V=%h Q=%0d", $time,
                 bus.V1_to_dispatcher, bus.Q1_to_dispatcher, e1[37:6], e1[5:0]);
      end
      checks_n = checks_n + 1;
      if ({bus.V2_to_dispatcher, bus.Q2_to_dispatcher} !== e2) begin
        errors_n = errors_n + 1;
        $display("FAIL model_rs2 t=%0t got V=%h Q=%0d want V=%h Q=%0d", $time,
                 bus.V2_to_dispatcher, bus.Q2_to_dispatcher, e2[37:6], e2[5:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n = checks_n + 1;
    if (act !== exp) begin
      errors_n = errors_n + 1;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.enable_from_dispatcher = 1'b0;
    bus.rd_from_dispatcher     = 5'd0;
    bus.rob_id_from_dispatcher = 6'd0;
    bus.commit_flag            = 1'b0;
    bus.rd_from_rob            = 5'd0;
    bus.V_from_rob             = 32'd0;
    bus.Q_from_rob             = 6'd0;
    bus.rollback_flag          = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [5:0] id);
    bus.enable_from_dispatcher = 1'b1;
    bus.rd_from_dispatcher     = rd;
    bus.rob_id_from_dispatcher = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [5:0] q);
    bus.commit_flag = 1'b1;
    bus.rd_from_rob = rd;
    bus.V_from_rob  = v;
    bus.Q_from_rob  = q;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.rs1_from_dispatcher = 5'd0;
    bus.rs2_from_dispatcher = 5'd0;
    tick();
    tick();
    rst_in = 1'b0;

    // Reset state.
    bus.rs1_from_dispatcher = 5'd5;
    bus.rs2_from_dispatcher = 5'd31;
    #1;
    chk("reset_v1", bus.V1_to_dispatcher, 32'd0);
    chk("reset_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd0);
    chk("reset_v2", bus.V2_to_dispatcher, 32'd0);
    chk("reset_q2", {26'd0, bus.Q2_to_dispatcher}, 32'd0);

    // Rename x5 then commit it with bypass.
    rename(5'd5, 6'd3);
    tick();
    idle();
    #1;
    chk("rename_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd3);
    commit(5'd5, 32'h0000DEAD, 6'd3);
    #1;
    chk("bypass_v1", bus.V1_to_dispatcher, 32'h0000DEAD);
    chk("bypass_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd0);
    tick();
    idle();
    #1;
    chk("commit_v1", bus.V1_to_dispatcher, 32'h0000DEAD);
    chk("commit_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd0);

    // Stale commit: older producer of x7 retires, tag of younger kept.
    rename(5'd7, 6'd4);
    tick();
    rename(5'd7, 6'd9);
    tick();
    idle();
    bus.rs2_from_dispatcher = 5'd7;
    commit(5'd7, 32'h00000011, 6'd4);
    #1;
    chk("stale_nobypass_v2", bus.V2_to_dispatcher, 32'd0);
    chk("stale_nobypass_q2", {26'd0, bus.Q2_to_dispatcher}, 32'd9);
    tick();
    idle();
    #1;
    chk("stale_v2", bus.V2_to_dispatcher, 32'h00000011);
    chk("stale_q2", {26'd0, bus.Q2_to_dispatcher}, 32'd9);

    // Same-cycle commit and rename of x8: rename tag wins, data written.
    rename(5'd8, 6'd2);
    tick();
    idle();
    bus.rs1_from_dispatcher = 5'd8;
    commit(5'd8, 32'h00000055, 6'd2);
    rename(5'd8, 6'd12);
    #1;
    chk("samecyc_bypass_v1", bus.V1_to_dispatcher, 32'h00000055);
    tick();
    idle();
    #1;
    chk("samecyc_v1", bus.V1_to_dispatcher, 32'h00000055);
    chk("samecyc_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd12);

    // Rollback with a link-value commit and an ignored rename.
    for (int i = 1; i <= 4; i++) begin
      rename(i[4:0], i[5:0]);
      tick();
    end
    idle();
    bus.rollback_flag = 1'b1;
    commit(5'd1, 32'h00000080, 6'd1);
    rename(5'd6, 6'd5);
    tick();
    idle();
    bus.rs1_from_dispatcher = 5'd1;
    bus.rs2_from_dispatcher = 5'd6;
    #1;
    chk("rollback_v1", bus.V1_to_dispatcher, 32'h00000080);
    chk("rollback_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd0);
    chk("rollback_q2_x6", {26'd0, bus.Q2_to_dispatcher}, 32'd0);
    bus.rs1_from_dispatcher = 5'd2;
    bus.rs2_from_dispatcher = 5'd7;
    #1;
    chk("rollback_q1_x2", {26'd0, bus.Q1_to_dispatcher}, 32'd0);
    chk("rollback_q2_x7", {26'd0, bus.Q2_to_dispatcher}, 32'd0);
    chk("rollback_v2_x7", bus.V2_to_dispatcher, 32'h00000011);
    tick();

    // x0 ignores rename and commit.
    rename(5'd0, 6'd7);
    commit(5'd0, 32'h000000FF, 6'd0);
    bus.rs1_from_dispatcher = 5'd0;
    #1;
    chk("x0_same_v1", bus.V1_to_dispatcher, 32'd0);
    tick();
    idle();
    #1;
    chk("x0_v1", bus.V1_to_dispatcher, 32'd0);
    chk("x0_q1", {26'd0, bus.Q1_to_dispatcher}, 32'd0);

    // rdy_in low holds all state.
    rdy_in = 1'b0;
    rename(5'd9, 6'd6);
    commit(5'd5, 32'h0000BEEF, 6'd0);
    tick();
    tick();
    idle();
    rdy_in = 1'b1;
    bus.rs1_from_dispatcher = 5'd9;
    bus.rs2_from_dispatcher = 5'd5;
    #1;
    chk("hold_q1_x9", {26'd0, bus.Q1_to_dispatcher}, 32'd0);
    chk("hold_v2_x5", bus.V2_to_dispatcher, 32'h0000DEAD);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end
endmodule
